// File: rtl/gin_multicast_network.sv
// Purpose: GLB->PE input network; one tagged word is multicast to every PE whose (YID,XID) matches its (tag_Y,tag_X).
// Latency: accept at edge t -> PE_valid at t+1; one word per cycle sustained when all targets are ready.
// Backpressure: single-entry buffer; GIN_ready = buffer empty or all remaining targets ready this cycle (comb PE_ready path).
module gin_multicast_network #(
    parameter int NUMS_PE_ROW = 6,
    parameter int NUMS_PE_COL = 8,
    parameter int DATA_BITS   = 32,
    parameter int XID_BITS    = 5,
    parameter int YID_BITS    = 4
) (
    input  logic                                         clk,
    input  logic                                         rst,
    input  logic                                         GIN_valid,
    output logic                                         GIN_ready,
    input  logic [DATA_BITS-1:0]                         GIN_data,
    input  logic [XID_BITS-1:0]                          tag_X,
    input  logic [YID_BITS-1:0]                          tag_Y,
    input  logic                                         set_XID,
    input  logic [XID_BITS-1:0]                          XID_scan_in,
    input  logic                                         set_YID,
    input  logic [YID_BITS-1:0]                          YID_scan_in,
    output logic [NUMS_PE_ROW*NUMS_PE_COL-1:0]           PE_valid,
    input  logic [NUMS_PE_ROW*NUMS_PE_COL-1:0]           PE_ready,
    output logic [DATA_BITS*NUMS_PE_ROW*NUMS_PE_COL-1:0] PE_data
);

    localparam int NUM_PE = NUMS_PE_ROW * NUMS_PE_COL;

    typedef enum logic {
        IDLE    = 1'b0,
        DELIVER = 1'b1
    } state_t;

    state_t                state;
    logic [NUM_PE-1:0]     mask;
    logic [DATA_BITS-1:0]  buf_data;
    logic [YID_BITS-1:0]   yid [NUMS_PE_ROW];
    logic [XID_BITS-1:0]   xid [NUM_PE];

    logic [NUM_PE-1:0]     match_mask;
    logic                  completion;
    logic                  accept;

    // Per-row ID chain: row 0 takes the scan input, every other row takes its predecessor.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int r = 0; r < NUMS_PE_ROW; r++) yid[r] <= '0;
        end else if (set_YID) begin
            yid[0] <= YID_scan_in;
            for (int r = 1; r < NUMS_PE_ROW; r++) yid[r] <= yid[r-1];
        end
    end

    // Per-PE ID chain, row-major: PE 0 takes the scan input, PE p takes PE p-1.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int p = 0; p < NUM_PE; p++) xid[p] <= '0;
        end else if (set_XID) begin
            xid[0] <= XID_scan_in;
            for (int p = 1; p < NUM_PE; p++) xid[p] <= xid[p-1];
        end
    end

    // Target set for the word on the GIN port, built from the IDs as they stand before any shift this cycle.
    always_comb begin
        match_mask = '0;
        for (int p = 0; p < NUM_PE; p++) begin
            match_mask[p] = (yid[p / NUMS_PE_COL] == tag_Y) && (xid[p] == tag_X);
        end
    end

    // The word retires when every target still owed the word is ready now (trivially true for zero targets).
    always_comb begin
        completion = (state == DELIVER) && ((mask & ~PE_ready) == '0);
        GIN_ready  = (state == IDLE) || completion;
        accept     = GIN_valid && GIN_ready;
    end

    // Buffer FSM: latch word and target mask on accept, retire served targets, free or reload on completion.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            mask     <= '0;
            buf_data <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        state    <= DELIVER;
                        mask     <= match_mask;
                        buf_data <= GIN_data;
                    end
                end
                DELIVER: begin
                    if (accept) begin
                        mask     <= match_mask;
                        buf_data <= GIN_data;
                    end else if (completion) begin
                        state <= IDLE;
                        mask  <= '0;
                    end else begin
                        mask <= mask & ~PE_ready;
                    end
                end
                default: begin
                    state <= IDLE;
                    mask  <= '0;
                end
            endcase
        end
    end

    // mask is zero whenever the buffer is empty, so it drives PE_valid straight from flops.
    assign PE_valid = mask;
    assign PE_data  = {NUM_PE{buf_data}};

endmodule

// File: tb/tb_gin_multicast_network.sv
module tb_gin_multicast_network;

    localparam int NR  = 6;
    localparam int NC  = 8;
    localparam int NPE = NR * NC;
    localparam int DW  = 32;

    typedef struct packed {
        logic [NPE-1:0] mask;
        logic [DW-1:0]  data;
    } exp_t;

    logic              clk;
    logic              rst;
    logic              gin_valid;
    logic              gin_ready;
    logic [DW-1:0]     gin_data;
    logic [4:0]        tag_x;
    logic [3:0]        tag_y;
    logic              set_xid;
    logic [4:0]        xid_in;
    logic              set_yid;
    logic [3:0]        yid_in;
    logic [NPE-1:0]    pe_valid;
    logic [NPE-1:0]    pe_ready;
    logic [DW*NPE-1:0] pe_data;

    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];
    int   ym[NR];
    int   xm[NPE];

    gin_multicast_network #(
        .NUMS_PE_ROW(NR), .NUMS_PE_COL(NC), .DATA_BITS(DW), .XID_BITS(5), .YID_BITS(4)
    ) dut (
        .clk(clk), .rst(rst),
        .GIN_valid(gin_valid), .GIN_ready(gin_ready), .GIN_data(gin_data),
        .tag_X(tag_x), .tag_Y(tag_y),
        .set_XID(set_xid), .XID_scan_in(xid_in),
        .set_YID(set_yid), .YID_scan_in(yid_in),
        .PE_valid(pe_valid), .PE_ready(pe_ready), .PE_data(pe_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_data(input string tag, input logic [DW-1:0] d);
        int bad;
        bad = -1;
        for (int p = 0; p < NPE; p++)
            if (pe_data[p*DW +: DW] !== d && bad < 0) bad = p;
        if (bad < 0) bad = 0;
        checks++;
        assert (pe_data === {NPE{d}}) else begin
            errors++;
            $error("FAIL %s slice %0d observed=%0h expected=%0h", tag, bad, pe_data[bad*DW +: DW], d);
        end
    endtask

    function automatic logic [NPE-1:0] model_mask(input int ty, input int tx);
        logic [NPE-1:0] m;
        for (int p = 0; p < NPE; p++) m[p] = (ym[p / NC] == ty) && (xm[p] == tx);
        return m;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic model_shift_y(input int v);
        for (int r = NR - 1; r > 0; r--) ym[r] = ym[r-1];
        ym[0] = v;
    endtask

    task automatic model_shift_x(input int v);
        for (int p = NPE - 1; p > 0; p--) xm[p] = xm[p-1];
        xm[0] = v;
    endtask

    task automatic shift_y(input int v);
        set_yid = 1'b1;
        yid_in  = 4'(v);
        tick();
        model_shift_y(v);
        set_yid = 1'b0;
    endtask

    task automatic shift_x(input int v);
        set_xid = 1'b1;
        xid_in  = 5'(v);
        tick();
        model_shift_x(v);
        set_xid = 1'b0;
    endtask

    // Present a word; the expected target set comes from the bench's own ID model.
    task automatic put_word(input int ty, input int tx, input logic [DW-1:0] d);
        gin_valid = 1'b1;
        tag_y     = 4'(ty);
        tag_x     = 5'(tx);
        gin_data  = d;
        sb.push_back('{mask: model_mask(ty, tx), data: d});
    endtask

    task automatic pop_check(input string tag);
        exp_t e;
        if (sb.size() == 0) begin
            chk({tag, "_sb_empty"}, 64'd0, 64'd1);
        end else begin
            e = sb.pop_front();
            chk({tag, "_valid"}, 64'(pe_valid), 64'(e.mask));
            chk_data({tag, "_data"}, e.data);
        end
    endtask

    initial begin
        rst       = 1'b0;
        gin_valid = 1'b0;
        gin_data  = '0;
        tag_x     = '0;
        tag_y     = '0;
        set_xid   = 1'b0;
        xid_in    = '0;
        set_yid   = 1'b0;
        yid_in    = '0;
        pe_ready  = '1;
        for (int r = 0; r < NR; r++) ym[r] = 0;
        for (int p = 0; p < NPE; p++) xm[p] = 0;

        // Reset state
        sample();
        chk("rst_valid", 64'(pe_valid), 64'd0);
        chk_data("rst_data", 32'd0);
        tick();
        rst = 1'b1;
        sample();
        chk("rst_ready", 64'(gin_ready), 64'd1);
        tick();

        // 1: configure YID[r]=r, XID[p]=p%8
        for (int v = 5; v >= 0; v--) shift_y(v);
        for (int p = NPE - 1; p >= 0; p--) shift_x(p % NC);

        // 2: unicast to PE 19, then back-to-back word to PE 37
        put_word(2, 3, 32'hDEADBEEF);
        sample();
        chk("t2_ready0", 64'(gin_ready), 64'd1);
        tick();
        put_word(4, 5, 32'h12345678);
        sample();
        pop_check("t2_w0");
        chk("t2_pe19", 64'(pe_valid), 64'h1 << 19);
        chk("t2_slice19", 64'(pe_data[19*DW +: DW]), 64'hDEADBEEF);
        chk("t2_ready1", 64'(gin_ready), 64'd1);
        tick();
        gin_valid = 1'b0;
        sample();
        pop_check("t2_w1");
        chk("t2_pe37", 64'(pe_valid), 64'h1 << 37);
        chk("t2_ready2", 64'(gin_ready), 64'd1);
        tick();
        sample();
        chk("t2_idle", 64'(pe_valid), 64'd0);
        tick();

        // 3: partial multicast to row 1 with PE 10 stalling for 3 cycles
        for (int p = 0; p < NPE; p++) shift_x(0);
        pe_ready = ~(48'h1 << 10);
        put_word(1, 0, 32'hA5A50003);
        sample();
        chk("t3_ready_acc", 64'(gin_ready), 64'd1);
        tick();
        gin_valid = 1'b0;
        sample();
        pop_check("t3_first");
        chk("t3_row1", 64'(pe_valid), 64'hFF00);
        chk("t3_ready_c1", 64'(gin_ready), 64'd0);
        tick();
        for (int i = 2; i <= 3; i++) begin
            sample();
            chk($sformatf("t3_hold%0d", i), 64'(pe_valid), 64'h1 << 10);
            chk($sformatf("t3_block%0d", i), 64'(gin_ready), 64'd0);
            chk_data($sformatf("t3_stable%0d", i), 32'hA5A50003);
            tick();
        end
        pe_ready = '1;
        sample();
        chk("t3_last", 64'(pe_valid), 64'h1 << 10);
        chk("t3_ready_done", 64'(gin_ready), 64'd1);
        tick();
        sample();
        chk("t3_idle", 64'(pe_valid), 64'd0);
        tick();

        // 4: broadcast to all 48 PEs
        for (int r = 0; r < NR; r++) shift_y(0);
        put_word(0, 0, 32'hCAFEF00D);
        sample();
        chk("t4_ready", 64'(gin_ready), 64'd1);
        tick();
        gin_valid = 1'b0;
        sample();
        pop_check("t4_bcast");
        chk("t4_all", 64'(pe_valid), 64'hFFFF_FFFF_FFFF);
        tick();
        sample();
        chk("t4_idle", 64'(pe_valid), 64'd0);
        tick();

        // 5: non-matching words retire in one cycle each, ready stays high
        for (int i = 0; i < 3; i++) begin
            put_word(7, 0, 32'h5000 + i);
            sample();
            chk($sformatf("t5_ready%0d", i), 64'(gin_ready), 64'd1);
            if (i > 0) pop_check($sformatf("t5_w%0d", i - 1));
            tick();
        end
        gin_valid = 1'b0;
        sample();
        pop_check("t5_w2");
        chk("t5_ready_end", 64'(gin_ready), 64'd1);
        tick();

        // 6a: accept while shifting YID uses the pre-shift IDs
        put_word(0, 0, 32'h11110000);
        set_yid = 1'b1;
        yid_in  = 4'd3;
        sample();
        chk("t6a_ready", 64'(gin_ready), 64'd1);
        tick();
        model_shift_y(3);
        set_yid   = 1'b0;
        gin_valid = 1'b0;
        sample();
        pop_check("t6a_oldids");
        tick();

        // 6b: ID shifts during DELIVER leave the latched mask alone
        pe_ready = '0;
        put_word(0, 0, 32'h22220000);
        sample();
        chk("t6b_ready", 64'(gin_ready), 64'd1);
        tick();
        gin_valid = 1'b0;
        set_yid   = 1'b1;
        yid_in    = 4'd5;
        sample();
        pop_check("t6b_first");
        chk("t6b_block", 64'(gin_ready), 64'd0);
        tick();
        model_shift_y(5);
        set_yid = 1'b0;
        set_xid = 1'b1;
        xid_in  = 5'd7;
        sample();
        chk("t6b_hold_y", 64'(pe_valid), 64'hFFFF_FFFF_FF00);
        tick();
        model_shift_x(7);
        set_xid = 1'b0;
        sample();
        chk("t6b_hold_x", 64'(pe_valid), 64'hFFFF_FFFF_FF00);

        // 6c: asynchronous reset mid-DELIVER drops the word and clears the IDs
        #1;
        rst = 1'b0;
        #1;
        chk("t6c_valid", 64'(pe_valid), 64'd0);
        chk_data("t6c_data", 32'd0);
        for (int r = 0; r < NR; r++) ym[r] = 0;
        for (int p = 0; p < NPE; p++) xm[p] = 0;
        tick();
        rst      = 1'b1;
        pe_ready = '1;
        sample();
        chk("t6c_ready", 64'(gin_ready), 64'd1);
        chk("t6c_idle", 64'(pe_valid), 64'd0);
        tick();
        put_word(0, 0, 32'h33330000);
        tick();
        gin_valid = 1'b0;
        sample();
        pop_check("t6c_ids_cleared");
        tick();

        chk("sb_drained", 64'(sb.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
